// File: rtl/rom_arb_pkg.sv
// Shared constants and maze ROM types for the ROM read arbiter and romFile users.
// Optional stall counters are enabled with ROM_ARB_STALL_CNT_EN.
package rom_arb_pkg;

    localparam int unsigned DEF_NUM_REQ    = 6;
    localparam int unsigned DEF_NUM_READ   = 4;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    localparam int unsigned STALL_CNT_W = 8;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    typedef logic [DEF_ADDR_WIDTH-1:0] maze_addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] maze_data_t;

    // Index width that stays at least one bit for single-entry sets.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_multi_picker.sv
// Round-robin multi-grant scan: grants up to NUM_READ requests starting at rr_ptr,
// assigns each winner a ROM port in scan order and computes the next pointer.
import rom_arb_pkg::*;

module rr_multi_picker #(
    parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
    parameter int unsigned NUM_READ = DEF_NUM_READ,
    parameter int unsigned PTR_W    = idx_w(NUM_REQ),
    parameter int unsigned PORT_W   = idx_w(NUM_READ)
) (
    input  logic [NUM_REQ-1:0]             req,
    input  logic [PTR_W-1:0]               rr_ptr,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0][PORT_W-1:0] port_idx,
    output logic [PTR_W-1:0]               next_ptr
);

    localparam logic [PORT_W:0]  NR_L   = (PORT_W+1)'(NUM_READ);
    localparam logic [PTR_W-1:0] LAST_L = PTR_W'(NUM_REQ - 1);

    // Explicit wrap keeps non-power-of-two requester counts safe.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
        return (v == LAST_L) ? '0 : v + 1'b1;
    endfunction

    logic [PTR_W-1:0] idx;
    logic [PORT_W:0]  cnt;

    always_comb begin
        gnt      = '0;
        port_idx = '0;
        next_ptr = rr_ptr;
        idx      = rr_ptr;
        cnt      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[idx] && (cnt < NR_L)) begin
                gnt[idx]      = 1'b1;
                port_idx[idx] = cnt[PORT_W-1:0];
                cnt           = cnt + 1'b1;
                next_ptr      = wrap_inc(idx);
            end
            idx = wrap_inc(idx);
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares NUM_READ combinational ROM read ports among NUM_REQ requesters, round-robin.
// Define ROM_ARB_STALL_CNT_EN to add per-requester saturating stall counters (stall_cnt).
import rom_arb_pkg::*;

module rom_read_arbiter #(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned NUM_READ   = DEF_NUM_READ,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr,
    output logic [NUM_REQ-1:0]                    gnt,
    output logic [NUM_REQ-1:0]                    rsp_valid,
    output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    rsp_data,
    output logic [NUM_READ-1:0][ADDR_WIDTH-1:0]   rom_addr,
    input  logic [NUM_READ-1:0][DATA_WIDTH-1:0]   rom_data
`ifdef ROM_ARB_STALL_CNT_EN
    ,
    output logic [NUM_REQ-1:0][STALL_CNT_W-1:0]   stall_cnt
`endif
);

    localparam int unsigned PTR_W  = idx_w(NUM_REQ);
    localparam int unsigned PORT_W = idx_w(NUM_READ);

    if ((NUM_READ < 1) || (NUM_READ > NUM_REQ)) begin : g_bad_cfg
        $error("rom_read_arbiter: NUM_READ must lie in 1..NUM_REQ");
    end

    logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d, next_ptr;
    logic [NUM_REQ-1:0]                 rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0][PORT_W-1:0]     port_idx;

    rr_multi_picker #(
        .NUM_REQ  (NUM_REQ),
        .NUM_READ (NUM_READ),
        .PTR_W    (PTR_W),
        .PORT_W   (PORT_W)
    ) u_picker (
        .req      (req),
        .rr_ptr   (rr_ptr_q),
        .gnt      (gnt),
        .port_idx (port_idx),
        .next_ptr (next_ptr)
    );

    // Port steering kept apart from the response path: rom_data is a function of rom_addr.
    always_comb begin
        rom_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) rom_addr[port_idx[i]] = req_addr[i];
        end
    end

    always_comb begin
        rr_ptr_d    = next_ptr;
        rsp_valid_d = gnt;
        rsp_data_d  = rsp_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) rsp_data_d[i] = rom_data[port_idx[i]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

`ifdef ROM_ARB_STALL_CNT_EN
    logic [NUM_REQ-1:0][STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i])
                stall_cnt_d[i] = '0;
            else if (req[i] && (stall_cnt_q[i] != STALL_CNT_MAX))
                stall_cnt_d[i] = stall_cnt_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/rom_read_arbiter.md
ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 6: number of requesters (Pac-Man, ghosts, spare).
REQ-002 Parameter NUM_READ, default 4: ROM read ports shared; SHALL satisfy 1 <= NUM_READ <= NUM_REQ, else elaboration error.
REQ-003 Parameter ADDR_WIDTH, default 5: ROM address bits.
REQ-004 Parameter DATA_WIDTH, default 32: ROM word bits.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 req  in  [NUM_REQ]  per-requester read request.
REQ-008 req_addr  in  [NUM_REQ][ADDR_WIDTH]  per-requester read address.
REQ-009 gnt  out  [NUM_REQ]  combinational grant, same cycle as accepted req.
REQ-010 rsp_valid  out  [NUM_REQ]  registered; read data valid.
REQ-011 rsp_data  out  [NUM_REQ][DATA_WIDTH]  registered read data.
REQ-012 rom_addr  out  [NUM_READ][ADDR_WIDTH]  to romFile r_addr.
REQ-013 rom_data  in  [NUM_READ][DATA_WIDTH]  from romFile r_data (combinational read).

Function
REQ-014 Each cycle SHALL grant up to NUM_READ asserted requests, scanning indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first NUM_READ asserted SHALL be granted.
REQ-015 k-th granted requester (k = 0..NUM_READ-1 in scan order) SHALL drive rom_addr[k] = its req_addr; unused ports SHALL drive 0.
REQ-016 gnt[i] SHALL be 0 whenever req[i] is 0.
REQ-017 Latency: requester granted in cycle t SHALL see rsp_valid[i]=1 and rsp_data[i]=rom_data[k] sampled at t, in cycle t+1 only.
REQ-018 rsp_valid[i] SHALL be 0 in cycles following non-granted cycles; rsp_data[i] SHALL hold its last value when not valid.
REQ-019 rr_ptr SHALL update to (index of last granted requester + 1) mod NUM_REQ; unchanged when no grant.
REQ-020 Handshake: requester SHALL hold req and req_addr stable until gnt; req held high after gnt SHALL issue a new read (back-to-back, one per cycle).
REQ-021 Fairness: a continuously asserted request SHALL be granted within ceil(NUM_REQ/NUM_READ) cycles.
REQ-022 When count of requests <= NUM_READ, all SHALL be granted same cycle.
REQ-023 rr_ptr width SHALL be $clog2(NUM_REQ), wrap from NUM_REQ-1 to 0 explicitly (non-power-of-two safe).

Reset
REQ-024 rst_n low SHALL asynchronously clear rr_ptr=0, rsp_valid=0, rsp_data=0.
REQ-025 Reset mid-operation SHALL discard in-flight responses; gnt remains combinational from req during reset but no response SHALL follow.
REQ-026 First cycle after release SHALL scan from index 0.

Configuration
REQ-027 Macro ROM_ARB_STALL_CNT_EN: when defined, output port stall_cnt [NUM_REQ][8] SHALL exist; per requester, saturating at 255, incremented each cycle req&!gnt, cleared on gnt or reset.
REQ-028 Without ROM_ARB_STALL_CNT_EN, stall_cnt port and counters SHALL not exist; all other behaviour identical.

Structure
REQ-029 Package rom_arb_pkg SHALL hold default parameter constants, stall counter width (8) and the maze address/data typedefs shared with romFile users.
REQ-030 Sub-module rr_multi_picker SHALL implement the round-robin multi-grant scan (req, rr_ptr in; gnt, port-index per requester, next_ptr out); registers stay in rom_read_arbiter.

Verification
REQ-031 Single req[2]=1, addr 7 -> gnt[2] same cycle, rom_addr[0]=7, next cycle rsp_valid[2]=1 with ROM word 7.
REQ-032 All 6 req high, rr_ptr=0 -> cycle 1 grants 0..3, cycle 2 grants 4,5,0,1, rr_ptr=2; every requester served within 2 cycles.
REQ-033 req 3 and 5 only, addr 31 and 0 -> both granted, ports 0/1, ports 2/3 addr 0.
REQ-034 rst_n pulsed low one cycle after grant to req[1] -> rsp_valid[1] stays 0, rr_ptr=0 after release.
REQ-035 ROM_ARB_STALL_CNT_EN, req[5] blocked by 4 lower requesters persistently held for 300 cycles with rr_ptr forced by pattern -> stall_cnt saturates 255, clears on gnt.
REQ-036 Random req/addr 10k cycles vs reference model -> rsp_data matches ROM contents, no more than NUM_READ grants per cycle.
